// File: rtl/cnn_seq_pkg.sv
// Shared types and the constant LeNet layer table for the CNN layer sequencer.
// Also used by any block that needs to decode a layer index into its configuration.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } seq_state_t;

  typedef struct packed {
    logic       is_fc;
    logic [1:0] nth;
    logic [4:0] ofmap;
    logic [5:0] ch;
    logic [8:0] in_nodes;
    logic [6:0] out_nodes;
  } layer_cfg_t;

  localparam int LAYER_NUM = 5;

  localparam logic [1:0] START_WAIT = 2'd0;
  localparam logic [1:0] START_SA   = 2'd1;
  localparam logic [1:0] START_FC   = 2'd2;

  // Fields that do not apply to a layer type are zero so they can be driven as-is.
  localparam layer_cfg_t LAYER_TABLE [LAYER_NUM] = '{
    '{is_fc: 1'b0, nth: 2'd0, ofmap: 5'd28, ch: 6'd1, in_nodes: 9'd0,   out_nodes: 7'd0},
    '{is_fc: 1'b0, nth: 2'd1, ofmap: 5'd10, ch: 6'd6, in_nodes: 9'd0,   out_nodes: 7'd0},
    '{is_fc: 1'b1, nth: 2'd0, ofmap: 5'd0,  ch: 6'd0, in_nodes: 9'd400, out_nodes: 7'd120},
    '{is_fc: 1'b1, nth: 2'd1, ofmap: 5'd0,  ch: 6'd0, in_nodes: 9'd120, out_nodes: 7'd84},
    '{is_fc: 1'b1, nth: 2'd2, ofmap: 5'd0,  ch: 6'd0, in_nodes: 9'd84,  out_nodes: 7'd10}
  };

  function automatic layer_cfg_t layer_cfg(input logic [2:0] idx);
    layer_cfg_t cfg;
    cfg = '0;
    if (int'(idx) < LAYER_NUM) cfg = LAYER_TABLE[idx];
    return cfg;
  endfunction

  function automatic logic layer_is_fc(input logic [2:0] idx);
    layer_cfg_t cfg;
    cfg = layer_cfg(idx);
    return cfg.is_fc;
  endfunction

endpackage

// File: rtl/cnn_layer_sequencer_lane_tracker.sv
// Sticky per-lane completion mask; all_seen includes the current cycle's lane flags.
module lane_last_tracker #(
  parameter int LANES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [LANES-1:0] lanes,
  output logic             all_seen
);

  logic [LANES-1:0] mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else if (clear) begin
      mask_q <= '0;
    end else if (en) begin
      mask_q <= mask_q | lanes;
    end
  end

  assign all_seen = &(mask_q | ({LANES{en}} & lanes));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Walks the five LeNet layers, driving accelerator start/config and waiting for each
// layer's completion, with an inter-layer gap, a per-layer timeout and host abort.
module cnn_layer_sequencer #(
  parameter int IDLE_GAP    = 4,
  parameter int TIMEOUT_CYC = 2**20,
  parameter int TO_W        = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  input  logic        abort_i,
  input  logic [15:0] pool_last_i,
  input  logic        act_last_i,
  output logic [1:0]  start_o,
  output logic [1:0]  nth_o,
  output logic [4:0]  ofmap_size_o,
  output logic [5:0]  ifmap_ch_o,
  output logic [8:0]  in_node_num_o,
  output logic [6:0]  out_node_num_o,
  output logic [2:0]  layer_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  import cnn_seq_pkg::*;

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  seq_state_t       state, state_n;
  logic [2:0]       layer_q, layer_n;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             lanes_done, layer_done, to_hit, gap_end, last_layer;
  layer_cfg_t       nxt_cfg;

  logic [1:0]       start_n;
  logic             busy_n, done_n, err_n;

  lane_last_tracker #(.LANES(16)) u_lane_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == ST_SETUP),
    .en       (state == ST_RUN),
    .lanes    (pool_last_i),
    .all_seen (lanes_done)
  );

  assign layer_done = layer_is_fc(layer_q) ? act_last_i : lanes_done;
  assign to_hit     = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign gap_end    = (gap_cnt == GAP_W'(IDLE_GAP - 1));
  assign last_layer = (layer_q == 3'(LAYER_NUM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      layer_q <= '0;
      to_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      layer_q <= layer_n;
      to_cnt  <= (state == ST_RUN) ? to_cnt + TO_W'(1) : '0;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

  // Completion is checked before timeout so a layer finishing on its last allowed cycle advances.
  always_comb begin
    state_n = state;
    layer_n = layer_q;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (run_i) begin
          state_n = ST_SETUP;
          layer_n = '0;
        end
      end
      ST_SETUP: state_n = ST_RUN;
      ST_RUN: begin
        if (layer_done) state_n = last_layer ? ST_DONE : ST_GAP;
        else if (to_hit) state_n = ST_ERR;
      end
      ST_GAP: begin
        if (gap_end) begin
          state_n = ST_SETUP;
          layer_n = layer_q + 3'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort_i) begin
      state_n = ST_IDLE;
      layer_n = '0;
    end
  end

  // Outputs are decoded from the next state so they can be registered without extra latency.
  always_comb begin
    nxt_cfg = '0;
    start_n = START_WAIT;
    busy_n  = 1'b0;
    if (state_n inside {ST_SETUP, ST_RUN, ST_GAP}) begin
      nxt_cfg = layer_cfg(layer_n);
      busy_n  = 1'b1;
    end
    if (state_n == ST_RUN) start_n = nxt_cfg.is_fc ? START_FC : START_SA;
    done_n = (state_n == ST_DONE) && (state != ST_DONE);
    err_n  = (state_n == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_o        <= START_WAIT;
      nth_o          <= '0;
      ofmap_size_o   <= '0;
      ifmap_ch_o     <= '0;
      in_node_num_o  <= '0;
      out_node_num_o <= '0;
      layer_o        <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      start_o        <= start_n;
      nth_o          <= nxt_cfg.nth;
      ofmap_size_o   <= nxt_cfg.ofmap;
      ifmap_ch_o     <= nxt_cfg.ch;
      in_node_num_o  <= nxt_cfg.in_nodes;
      out_node_num_o <= nxt_cfg.out_nodes;
      layer_o        <= layer_n;
      busy_o         <= busy_n;
      done_o         <= done_n;
      err_o          <= err_n;
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_cnn_layer_sequencer;

  localparam int GAP     = 4;
  localparam int TIMEOUT = 100;

  localparam int OFMAP_T [5] = '{28, 10, 0, 0, 0};
  localparam int CH_T    [5] = '{1, 6, 0, 0, 0};
  localparam int IN_T    [5] = '{0, 0, 400, 120, 84};
  localparam int OUT_T   [5] = '{0, 0, 120, 84, 10};
  localparam int NTH_T   [5] = '{0, 1, 0, 1, 2};
  localparam int CODE_T  [5] = '{1, 1, 2, 2, 2};

  localparam int P_IDLE  = 0;
  localparam int P_SETUP = 1;
  localparam int P_RUN   = 2;
  localparam int P_GAP   = 3;
  localparam int P_DONE  = 4;
  localparam int P_ERR   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] pool_last_i = '0;
  logic        act_last_i = 1'b0;
  logic [1:0]  start_o;
  logic [1:0]  nth_o;
  logic [4:0]  ofmap_size_o;
  logic [5:0]  ifmap_ch_o;
  logic [8:0]  in_node_num_o;
  logic [6:0]  out_node_num_o;
  logic [2:0]  layer_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  cnn_layer_sequencer #(
    .IDLE_GAP    (GAP),
    .TIMEOUT_CYC (TIMEOUT),
    .TO_W        (21)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run_i          (run_i),
    .abort_i        (abort_i),
    .pool_last_i    (pool_last_i),
    .act_last_i     (act_last_i),
    .start_o        (start_o),
    .nth_o          (nth_o),
    .ofmap_size_o   (ofmap_size_o),
    .ifmap_ch_o     (ifmap_ch_o),
    .in_node_num_o  (in_node_num_o),
    .out_node_num_o (out_node_num_o),
    .layer_o        (layer_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: which phase of the walk we are in, how long we have been there,
  // and which pool lanes have reported since the layer started running.
  int          m_phase = P_IDLE;
  int          m_layer = 0;
  int          m_ticks = 0;
  logic [15:0] m_seen  = '0;
  bit          m_done_now = 1'b0;

  task automatic model_reset();
    m_phase    = P_IDLE;
    m_layer    = 0;
    m_ticks    = 0;
    m_seen     = '0;
    m_done_now = 1'b0;
  endtask

  task automatic model_step();
    bit finished;
    m_done_now = 1'b0;
    if (abort_i) begin
      m_phase = P_IDLE;
      m_layer = 0;
    end else if (m_phase == P_IDLE || m_phase == P_DONE || m_phase == P_ERR) begin
      if (run_i) begin
        m_phase = P_SETUP;
        m_layer = 0;
      end
    end else if (m_phase == P_SETUP) begin
      m_phase = P_RUN;
      m_ticks = 0;
      m_seen  = '0;
    end else if (m_phase == P_RUN) begin
      m_ticks++;
      m_seen = m_seen | pool_last_i;
      finished = (m_layer >= 2) ? act_last_i : (m_seen == 16'hFFFF);
      if (finished) begin
        if (m_layer == 4) begin
          m_phase    = P_DONE;
          m_done_now = 1'b1;
        end else begin
          m_phase = P_GAP;
          m_ticks = 0;
        end
      end else if (m_ticks == TIMEOUT) begin
        m_phase = P_ERR;
      end
    end else if (m_phase == P_GAP) begin
      m_ticks++;
      if (m_ticks == GAP) begin
        m_phase = P_SETUP;
        m_layer++;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  function automatic bit m_active();
    return (m_phase == P_SETUP) || (m_phase == P_RUN) || (m_phase == P_GAP);
  endfunction

  function automatic int m_start();
    if (m_phase != P_RUN) return 0;
    return CODE_T[m_layer];
  endfunction

  function automatic int m_field(input int which);
    if (!m_active()) return 0;
    case (which)
      0: return NTH_T[m_layer];
      1: return OFMAP_T[m_layer];
      2: return CH_T[m_layer];
      3: return IN_T[m_layer];
      default: return OUT_T[m_layer];
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cyc_start", start_o, m_start());
      checkOutput("cyc_nth", nth_o, m_field(0));
      checkOutput("cyc_ofmap", ofmap_size_o, m_field(1));
      checkOutput("cyc_ch", ifmap_ch_o, m_field(2));
      checkOutput("cyc_in_nodes", in_node_num_o, m_field(3));
      checkOutput("cyc_out_nodes", out_node_num_o, m_field(4));
      checkOutput("cyc_layer", layer_o, m_layer);
      checkOutput("cyc_busy", busy_o, int'(m_active()));
      checkOutput("cyc_done", done_o, int'(m_done_now));
      checkOutput("cyc_err", err_o, int'(m_phase == P_ERR));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    while (start_o == 2'd0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Called on the first RUN cycle; signals completion in RUN cycle number 'delay'.
  task automatic applyStimulus(input int lyr, input int delay);
    repeat (delay - 1) tick();
    if (lyr < 2) pool_last_i = 16'hFFFF;
    else act_last_i = 1'b1;
    tick();
    pool_last_i = '0;
    act_last_i  = 1'b0;
  endtask

  task automatic pulse_run();
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_start"}, start_o, 0);
    checkOutput({tag, "_nth"}, nth_o, 0);
    checkOutput({tag, "_ofmap"}, ofmap_size_o, 0);
    checkOutput({tag, "_ch"}, ifmap_ch_o, 0);
    checkOutput({tag, "_in"}, in_node_num_o, 0);
    checkOutput({tag, "_out"}, out_node_num_o, 0);
    checkOutput({tag, "_layer"}, layer_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    int n;
    int pre;

    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    $display("[TB] full run with spurious completions and run_i while busy");
    pulse_run();
    checkOutput("setup_start", start_o, 0);
    checkOutput("setup_busy", busy_o, 1);
    checkOutput("setup_ofmap", ofmap_size_o, 28);
    checkOutput("setup_ch", ifmap_ch_o, 1);
    pre = 0;
    for (int l = 0; l < 5; l++) begin
      wait_start(20, n);
      checkOutput("zero_cycles_before_start", n + pre, (l == 0) ? 1 : GAP + 1);
      checkOutput("start_code", start_o, CODE_T[l]);
      checkOutput("nth_index", nth_o, NTH_T[l]);
      checkOutput("layer_index", layer_o, l);
      checkOutput("in_nodes", in_node_num_o, IN_T[l]);
      checkOutput("out_nodes", out_node_num_o, OUT_T[l]);
      pre = 0;
      if (l == 0) begin
        repeat (9) tick();
        act_last_i = 1'b1;
        tick();
        act_last_i = 1'b0;
        tick();
        checkOutput("spurious_act_ignored", start_o, 1);
        applyStimulus(0, 39);
        checkOutput("stop_after_completion", start_o, 0);
        pool_last_i = 16'hFFFF;
        tick();
        pool_last_i = '0;
        pre = 1;
      end else if (l == 1) begin
        repeat (5) tick();
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
        checkOutput("run_while_busy_layer", layer_o, 1);
        checkOutput("run_while_busy_start", start_o, 1);
        applyStimulus(1, 44);
        checkOutput("stop_after_completion", start_o, 0);
      end else begin
        applyStimulus(l, 30);
        checkOutput("stop_after_completion", start_o, 0);
      end
    end
    checkOutput("done_pulse", done_o, 1);
    checkOutput("done_layer", layer_o, 4);
    checkOutput("done_busy", busy_o, 0);
    tick();
    checkOutput("done_single", done_o, 0);
    checkOutput("end_layer", layer_o, 4);

    $display("[TB] staggered lanes in L0");
    pulse_run();
    wait_start(20, n);
    repeat (3) tick();
    pool_last_i = 16'h00FF;
    tick();
    pool_last_i = '0;
    repeat (9) tick();
    checkOutput("half_lanes_hold", start_o, 1);
    pool_last_i = 16'hFF00;
    tick();
    pool_last_i = '0;
    checkOutput("staggered_drop", start_o, 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    $display("[TB] timeout in L2");
    pulse_run();
    for (int l = 0; l < 2; l++) begin
      wait_start(20, n);
      applyStimulus(l, 20);
    end
    wait_start(20, n);
    checkOutput("l2_start", start_o, 2);
    n = 0;
    while (start_o == 2'd2 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("timeout_run_cycles", n, TIMEOUT);
    checkOutput("timeout_err", err_o, 1);
    checkOutput("timeout_start", start_o, 0);
    checkOutput("timeout_busy", busy_o, 0);
    repeat (3) tick();
    checkOutput("err_sticky", err_o, 1);
    pulse_run();
    checkOutput("rerun_err_clear", err_o, 0);
    checkOutput("rerun_layer", layer_o, 0);
    checkOutput("rerun_ofmap", ofmap_size_o, 28);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    $display("[TB] abort in L3 RUN");
    pulse_run();
    for (int l = 0; l < 3; l++) begin
      wait_start(20, n);
      applyStimulus(l, 15);
    end
    wait_start(20, n);
    checkOutput("l3_start", start_o, 2);
    checkOutput("l3_layer", layer_o, 3);
    repeat (5) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_all_zero("abort");
    repeat (10) tick();
    checkOutput("abort_no_done", done_o, 0);

    $display("[TB] reset mid-L1");
    pulse_run();
    wait_start(20, n);
    applyStimulus(0, 10);
    wait_start(20, n);
    checkOutput("l1_start", start_o, 1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) tick();
    checkOutput("no_restart_after_reset", start_o, 0);
    checkOutput("idle_after_reset", busy_o, 0);

    $display("[TB] randomized traffic");
    repeat (3000) begin
      pool_last_i = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      act_last_i  = ($urandom_range(0, 19) == 0);
      abort_i     = ($urandom_range(0, 299) == 0);
      run_i       = ($urandom_range(0, 39) == 0);
      tick();
    end
    pool_last_i = '0;
    act_last_i  = 1'b0;
    abort_i     = 1'b0;
    run_i       = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Host-side layer sequencer driving the accelerator top's start/config inputs. On one run command it walks LeNet-style layers conv0, conv1, fc0, fc1, fc2. For each layer it drives the configuration, holds the start code, and waits for the layer-completion indication (pool lanes for conv, activation-last for FC). It then gaps and advances, reporting progress, completion and timeout to the host.

## Interface
Parameters:
- IDLE_GAP, 4: cycles with start = 0 between layers (≥1)
- TIMEOUT_CYC, 2**20: max cycles a layer may hold start before abort
- TO_W, 21: width of timeout counter (must hold TIMEOUT_CYC)

Ports:
- clk  in  1  clock; everything in this block uses this one clock
- rst  in  1  asynchronous, active-high reset
- run_i  in  1  one-cycle pulse; starts the sequence from layer 0; ignored unless in IDLE, DONE or ERR
- abort_i  in  1  level; forces return to IDLE next cycle; has priority over all events
- pool_last_i  in  16  per-lane pool-last flags from the accelerator
- act_last_i  in  1  FC activation-last pulse from the accelerator
- start_o  out  2  0 wait, 1 conv start, 2 fc start
- nth_o  out  2  nth conv / nth fully index
- ofmap_size_o  out  5  conv output map size
- ifmap_ch_o  out  6  conv input channels
- in_node_num_o  out  9  FC input nodes
- out_node_num_o  out  7  FC output nodes
- layer_o  out  3  current layer index 0..4
- busy_o  out  1  high outside IDLE/DONE/ERR
- done_o  out  1  one-cycle pulse when layer 4 completes
- err_o  out  1  sticky timeout flag; cleared by run_i or abort_i

## Operation
- Layer table (constant):
  - L0: conv, nth0, ofmap 28, ch 1
  - L1: conv, nth1, ofmap 10, ch 6
  - L2: fc, nth0, in 400, out 120
  - L3: fc, nth1, in 120, out 84
  - L4: fc, nth2, in 84, out 10
  - Unused fields of the table entry drive 0.
- FSM states: IDLE, SETUP, RUN, GAP, DONE, ERR.
- IDLE/DONE/ERR --run_i--> SETUP with layer = 0, err_o cleared.
- SETUP: config outputs take the table value, start_o = 0. Lasts exactly 1 cycle, then → RUN.
- RUN: start_o = 1 (conv) or 2 (fc), config held.
  - Conv completion: a 16-bit sticky lane mask ORs in pool_last_i each RUN cycle. The layer is complete in the cycle the mask reaches all ones, counting that cycle's input. Mask clears on entry to SETUP.
  - FC completion: act_last_i high during RUN.
  - On completion → GAP. If layer == 4, → DONE instead.
- GAP: start_o = 0, config held, IDLE_GAP cycles. Then layer++ and → SETUP.
- DONE: done_o pulses on the entry cycle only. Outputs otherwise as IDLE.
- Timeout: counter clears on RUN entry and increments each RUN cycle. If it reaches TIMEOUT_CYC before completion → ERR with err_o = 1 and start_o = 0.
- Completion signals received outside RUN are ignored.
- Completion and timeout in the same cycle: completion wins.
- abort_i: → IDLE, start_o = 0, layer 0, err_o cleared, no done_o.

## Timing
- Reset values: state IDLE. Then start_o, nth_o, ofmap_size_o, ifmap_ch_o, in_node_num_o, out_node_num_o, layer_o, busy_o, done_o and err_o are all 0.
- All outputs are registered; no combinational path from inputs to outputs.
- run_i at cycle t → SETUP at t+1 (config valid) → start_o nonzero at t+2.
- Completion sampled at t → start_o = 0 at t+1. The next layer's start_o rises at t+1+IDLE_GAP+1.
- done_o is high in the cycle after L4 completion is sampled.
- Reset asserted mid-layer: start_o drops to 0 asynchronously. No restart until a new run_i.

## Structure
- Package cnn_seq_pkg holds:
  - state enum
  - layer_cfg_t struct (is_fc, nth, ofmap, ch, in_nodes, out_nodes)
  - LAYER_NUM = 5 and the constant LAYER_TABLE array
  - start code constants (START_WAIT, START_SA, START_FC)
- Sub-module lane_last_tracker: 16-bit sticky mask with clear input and an all-seen output. Reused by any future block that needs to collect lane completions.

## Test plan
- Full run, IDLE_GAP = 4: after run_i, drive pool_last_i = 16'hFFFF 50 cycles into L0 and L1, and act_last_i 30 cycles into L2–L4. Expected: start_o sequence 1,1,2,2,2 with nth 0,1,0,1,2, gaps of 4+1 zero cycles, done_o a single pulse, layer_o = 4 at end.
- Staggered lanes in L0: assert pool_last_i bits 0–7 in one cycle and bits 8–15 ten cycles later. Expected: start_o drops exactly 1 cycle after the second assertion.
- Spurious completions: pulse act_last_i during L0, and pool_last_i = 16'hFFFF during GAP. Expected: no layer advance.
- Timeout, TIMEOUT_CYC = 100: no completion in L2. Expected: ERR after 100 RUN cycles, err_o = 1, start_o = 0. A following run_i clears err_o and restarts at L0.
- abort_i in L3 RUN: expected IDLE next cycle, all outputs 0, no done_o. Also assert rst mid-L1: all outputs 0 immediately.
- run_i while busy (L1): expected to be ignored, sequence unaffected.
